// File: rtl/qa_drv_fifo_to_host_if.sv
// Host-side write channel of the FIFO-to-host driver: line write request/header,
// the arbiter grant and the write-response stream.
interface qa_drv_fifo_to_host_if #(
    parameter int CACHE_WIDTH = 512,
    parameter int ADDR_WIDTH  = 32,
    parameter int MDATA_WIDTH = 12
);
    logic                   write_request;
    logic                   read_request;
    logic [3:0]             write_req_type;
    logic [ADDR_WIDTH-1:0]  write_addr;
    logic [MDATA_WIDTH-1:0] write_mdata;
    logic [CACHE_WIDTH-1:0] write_data;
    logic                   writer_grant;
    logic                   rx1_wrvalid;
    logic [MDATA_WIDTH-1:0] rx1_mdata;

    modport master (
        output write_request, read_request, write_req_type, write_addr, write_mdata, write_data,
        input  writer_grant, rx1_wrvalid, rx1_mdata
    );

    modport slave (
        input  write_request, read_request, write_req_type, write_addr, write_mdata, write_data,
        output writer_grant, rx1_wrvalid, rx1_mdata
    );
endinterface

// File: rtl/qa_drv_fifo_to_host.sv
// FPGA-to-host FIFO channel driver: packs UMF messages into cache lines and writes
// them into a host ring, publishing the newest line only once all writes are acknowledged.
module qa_drv_fifo_to_host #(
    parameter int              CACHE_WIDTH     = 512,
    parameter int              UMF_WIDTH       = 128,
    parameter int              MAX_OUTSTANDING = 8,
    parameter int              IDX_WIDTH       = 4,
    parameter int              ADDR_WIDTH      = 32,
    parameter int              MDATA_WIDTH     = 12,
    parameter logic [3:0]      REQ_WR_LINE     = 4'h2,
    parameter logic [11:0]     FIFO_WR_MDATA   = 12'h0A5
) (
    input  logic                  clk,
    input  logic                  resetb,
    qa_drv_fifo_to_host_if.master host,
    input  logic [UMF_WIDTH-1:0]  tx_data,
    input  logic [15:0]           tx_num_chunks,
    input  logic                  tx_enable,
    output logic                  tx_rdy,
    input  logic [ADDR_WIDTH-1:0] csr_afu_write_frame,
    input  logic [IDX_WIDTH-1:0]  oldest_write_line_idx,
    output logic [IDX_WIDTH-1:0]  newest_write_line_idx,
    output logic [1:0]            dbg_state,
    output logic [15:0]           dbg_num_writes
);
    localparam int CHUNKS = CACHE_WIDTH / UMF_WIDTH;
    localparam int CIDX_W = $clog2(CHUNKS);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        ST_NEW_MESSAGE = 2'd0,
        ST_FILL        = 2'd1,
        ST_WRITE       = 2'd2
    } state_e;

    state_e                             state_q, state_d;
    logic [CHUNKS-1:0][UMF_WIDTH-1:0]   line_q, line_d;
    logic [15:0]                        remaining_q, remaining_d;
    logic [CIDX_W-1:0]                  chunk_idx_q, chunk_idx_d;
    logic [IDX_WIDTH-1:0]               next_idx_q, next_idx_d;
    logic [OUT_W-1:0]                   outstanding_q, outstanding_d;
    logic [IDX_WIDTH-1:0]               newest_q, newest_d;
    logic [15:0]                        dbg_writes_q, dbg_writes_d;

    logic                 ack_s;
    logic                 can_issue_s;
    logic                 write_req_s;
    logic                 grant_s;
    logic [IDX_WIDTH-1:0] idx_plus1_s;

    // Ring/credit gating, packing FSM and outstanding-write accounting.
    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        remaining_d   = remaining_q;
        chunk_idx_d   = chunk_idx_q;
        next_idx_d    = next_idx_q;
        outstanding_d = outstanding_q;
        newest_d      = newest_q;
        dbg_writes_d  = dbg_writes_q;

        ack_s       = host.rx1_wrvalid && (host.rx1_mdata == FIFO_WR_MDATA[MDATA_WIDTH-1:0]);
        idx_plus1_s = next_idx_q + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
        // One ring slot stays empty so a full ring is distinguishable from an empty one.
        can_issue_s = (idx_plus1_s != oldest_write_line_idx) &&
                      (outstanding_q < OUT_W'(MAX_OUTSTANDING));
        write_req_s = (state_q == ST_WRITE) && can_issue_s;
        grant_s     = write_req_s && host.writer_grant;

        case (state_q)
            ST_NEW_MESSAGE: begin
                if (tx_enable) begin
                    line_d      = '0;
                    line_d[0]   = UMF_WIDTH'(tx_num_chunks);
                    line_d[1]   = tx_data;
                    remaining_d = tx_num_chunks - 16'd1;
                    chunk_idx_d = CIDX_W'(2);
                    if (tx_num_chunks == 16'd1) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_NEW_MESSAGE;
                end
            end
            ST_FILL: begin
                if (tx_enable) begin
                    line_d[chunk_idx_q] = tx_data;
                    remaining_d         = remaining_q - 16'd1;
                    chunk_idx_d         = chunk_idx_q + {{(CIDX_W-1){1'b0}}, 1'b1};
                    if ((remaining_q == 16'd1) || (chunk_idx_q == CIDX_W'(CHUNKS - 1))) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (grant_s) begin
                    line_d       = '0;
                    next_idx_d   = idx_plus1_s;
                    dbg_writes_d = dbg_writes_q + 16'd1;
                    chunk_idx_d  = '0;
                    if (remaining_q == 16'd0) begin
                        state_d = ST_NEW_MESSAGE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d = ST_NEW_MESSAGE;
            end
        endcase

        case ({grant_s, ack_s})
            2'b10:   outstanding_d = outstanding_q + {{(OUT_W-1){1'b0}}, 1'b1};
            2'b01:   outstanding_d = (outstanding_q == '0) ? outstanding_q
                                   : outstanding_q - {{(OUT_W-1){1'b0}}, 1'b1};
            default: outstanding_d = outstanding_q;
        endcase

        // Fence: the host only ever sees lines whose writes have all been acknowledged.
        if (outstanding_d == '0) begin
            newest_d = next_idx_q;
        end else begin
            newest_d = newest_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q       <= ST_NEW_MESSAGE;
            line_q        <= '0;
            remaining_q   <= 16'd0;
            chunk_idx_q   <= '0;
            next_idx_q    <= '0;
            outstanding_q <= '0;
            newest_q      <= '0;
            dbg_writes_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            remaining_q   <= remaining_d;
            chunk_idx_q   <= chunk_idx_d;
            next_idx_q    <= next_idx_d;
            outstanding_q <= outstanding_d;
            newest_q      <= newest_d;
            dbg_writes_q  <= dbg_writes_d;
        end
    end

    assign tx_rdy                = (state_q != ST_WRITE);
    assign host.write_request    = write_req_s;
    assign host.read_request     = 1'b0;
    assign host.write_req_type   = REQ_WR_LINE;
    assign host.write_addr       = csr_afu_write_frame + ADDR_WIDTH'(next_idx_q);
    assign host.write_mdata      = FIFO_WR_MDATA[MDATA_WIDTH-1:0];
    assign host.write_data       = line_q;
    assign newest_write_line_idx = newest_q;
    assign dbg_state             = state_q;
    assign dbg_num_writes        = dbg_writes_q;

    qa_drv_fifo_to_host_chk u_chk (
        .clk               (clk),
        .resetb            (resetb),
        .tx_enable         (tx_enable),
        .tx_rdy            (tx_rdy),
        .new_msg           (state_q == ST_NEW_MESSAGE),
        .tx_num_chunks     (tx_num_chunks),
        .writer_grant      (host.writer_grant),
        .write_request     (write_req_s),
        .ack               (ack_s),
        .outstanding_zero  (outstanding_q == '0)
    );
endmodule

// Protocol checker for the driver: illegal client pushes, spurious grants and responses.
module qa_drv_fifo_to_host_chk (
    input logic        clk,
    input logic        resetb,
    input logic        tx_enable,
    input logic        tx_rdy,
    input logic        new_msg,
    input logic [15:0] tx_num_chunks,
    input logic        writer_grant,
    input logic        write_request,
    input logic        ack,
    input logic        outstanding_zero
);
    a_tx_when_rdy: assert property (@(posedge clk) disable iff (!resetb) tx_enable |-> tx_rdy)
        else $fatal(1, "tx_enable while tx_rdy low");
    a_grant_req: assert property (@(posedge clk) disable iff (!resetb) writer_grant |-> write_request)
        else $fatal(1, "writer_grant without request");
    a_num_nonzero: assert property (@(posedge clk) disable iff (!resetb)
        (tx_enable && new_msg) |-> (tx_num_chunks != 16'd0))
        else $fatal(1, "tx_num_chunks zero at message start");
    a_ack_outstanding: assert property (@(posedge clk) disable iff (!resetb) ack |-> !outstanding_zero)
        else $fatal(1, "write response with nothing outstanding");
endmodule

// File: tb/tb_qa_drv_fifo_to_host.sv
// Scoreboard bench for qa_drv_fifo_to_host: directed messages push expected line writes,
// a monitor compares every granted write; directed status checks cover ring and fence behaviour.
module tb_qa_drv_fifo_to_host;
    localparam logic [31:0]  BASE = 32'h1000_0000;
    localparam logic [11:0]  MD   = 12'h0A5;

    logic         clk = 1'b0;
    logic         resetb;
    logic [127:0] tx_data;
    logic [15:0]  tx_num_chunks;
    logic         tx_enable;
    logic         tx_rdy;
    logic [3:0]   oldest;
    logic [3:0]   newest;
    logic [1:0]   dbg_state;
    logic [15:0]  dbg_num_writes;
    logic         grant_en;

    int n_cmp = 0;
    int n_err = 0;
    int grants_seen = 0;
    int acks_sent = 0;
    int ack_limit = 0;

    logic [31:0]  exp_addr[$];
    logic [511:0] exp_data[$];
    logic [127:0] d[6];

    qa_drv_fifo_to_host_if #(.CACHE_WIDTH(512), .ADDR_WIDTH(32), .MDATA_WIDTH(12)) host_if ();

    qa_drv_fifo_to_host dut (
        .clk                   (clk),
        .resetb                (resetb),
        .host                  (host_if),
        .tx_data               (tx_data),
        .tx_num_chunks         (tx_num_chunks),
        .tx_enable             (tx_enable),
        .tx_rdy                (tx_rdy),
        .csr_afu_write_frame   (BASE),
        .oldest_write_line_idx (oldest),
        .newest_write_line_idx (newest),
        .dbg_state             (dbg_state),
        .dbg_num_writes        (dbg_num_writes)
    );

    always #5 clk = ~clk;

    assign host_if.writer_grant = grant_en && host_if.write_request;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every granted write is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (resetb && host_if.write_request && host_if.writer_grant) begin
            grants_seen++;
            n_cmp++;
            if (exp_addr.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %0h expected no write", host_if.write_addr);
            end else begin
                logic [31:0]  ea;
                logic [511:0] ed;
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (host_if.write_addr !== ea || host_if.write_data !== ed ||
                    host_if.write_mdata !== MD || host_if.read_request !== 1'b0) begin
                    n_err++;
                    $display("FAIL write_line: got addr %0h data %0h expected addr %0h data %0h",
                             host_if.write_addr, host_if.write_data, ea, ed);
                end
            end
        end
    end

    // Host acknowledges each granted write one cycle later, up to ack_limit in total.
    always @(posedge clk) begin
        #2;
        if (resetb && (grants_seen > acks_sent) && (acks_sent < ack_limit)) begin
            host_if.rx1_wrvalid = 1'b1;
            host_if.rx1_mdata   = MD;
            acks_sent++;
        end else begin
            host_if.rx1_wrvalid = 1'b0;
            host_if.rx1_mdata   = 12'h000;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetb    = 1'b0;
        tx_enable = 1'b0;
        repeat (2) tick();
        resetb = 1'b1;
        tick();
    endtask

    task automatic send_chunk(input logic [15:0] num, input logic [127:0] data);
        int t = 0;
        while (!tx_rdy && t < 100) begin
            tick();
            t++;
        end
        if (!tx_rdy) begin
            check("tx_rdy_wait", {63'd0, tx_rdy}, 64'd1);
        end else begin
            tx_enable     = 1'b1;
            tx_num_chunks = num;
            tx_data       = data;
            tick();
            tx_enable = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [3:0] idx, input logic [511:0] line);
        exp_addr.push_back(BASE + {28'd0, idx});
        exp_data.push_back(line);
    endtask

    task automatic send_one(input logic [3:0] idx, input logic [127:0] data);
        push_exp(idx, {128'd0, 128'd0, data, 128'd1});
        send_chunk(16'd1, data);
    endtask

    task automatic wait_idle();
        int  t = 0;
        logic idle;
        idle = 1'b0;
        while (!idle && t < 300) begin
            idle = (exp_addr.size() == 0) && (grants_seen == acks_sent) &&
                   (host_if.rx1_wrvalid == 1'b0) && tx_rdy;
            if (!idle) tick();
            t++;
        end
        check("drain_idle", {63'd0, idle}, 64'd1);
        repeat (3) tick();
    endtask

    initial begin
        int g0;
        resetb = 1'b0; tx_enable = 1'b0; tx_data = '0; tx_num_chunks = 16'd0;
        oldest = 4'd0; grant_en = 1'b0;
        host_if.rx1_wrvalid = 1'b0; host_if.rx1_mdata = 12'h000;
        for (int i = 0; i < 6; i++) d[i] = {32'hD000_0000 + i, 96'h5A5A_5A5A_1234_5678_9ABC_DEF0};
        ack_limit = 1000000;
        do_reset();

        // Reset state
        check("rst_tx_rdy", {63'd0, tx_rdy}, 64'd1);
        check("rst_request", {63'd0, host_if.write_request}, 64'd0);
        check("rst_newest", {60'd0, newest}, 64'd0);
        check("rst_dbg_writes", {48'd0, dbg_num_writes}, 64'd0);

        // 1-chunk message, grant withheld at first
        push_exp(4'd0, {128'd0, 128'd0, 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF, 128'd1});
        send_chunk(16'd1, 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF);
        check("t1_req_latency", {63'd0, host_if.write_request}, 64'd1);
        check("t1_rdy_low", {63'd0, tx_rdy}, 64'd0);
        repeat (3) tick();
        check("t1_rdy_held", {63'd0, tx_rdy}, 64'd0);
        grant_en = 1'b1;
        wait_idle();
        check("t1_newest", {60'd0, newest}, 64'd1);
        check("t1_dbg_writes", {48'd0, dbg_num_writes}, 64'd1);

        // 6-chunk message spans two lines, second zero-padded
        do_reset();
        push_exp(4'd0, {d[2], d[1], d[0], 128'd6});
        push_exp(4'd1, {128'd0, d[5], d[4], d[3]});
        for (int i = 0; i < 6; i++) send_chunk(16'd6, d[i]);
        wait_idle();
        check("t2_newest", {60'd0, newest}, 64'd2);

        // Ring full: 15 lines fill a 16-entry ring with oldest=0
        do_reset();
        for (int i = 0; i < 15; i++) send_one(4'(i), 128'(i + 100));
        wait_idle();
        check("t3_newest15", {60'd0, newest}, 64'd15);
        send_one(4'd15, 128'd115);
        repeat (5) tick();
        check("t3_withheld", {63'd0, host_if.write_request}, 64'd0);
        check("t3_rdy_low", {63'd0, tx_rdy}, 64'd0);
        oldest = 4'd1;
        wait_idle();
        check("t3_newest_wrap", {60'd0, newest}, 64'd0);
        oldest = 4'd8;
        send_one(4'd0, 128'd116);
        wait_idle();
        check("t3_after_wrap", {60'd0, newest}, 64'd1);

        // Outstanding limit: acks withheld
        do_reset();
        oldest = 4'd0;
        ack_limit = acks_sent;
        g0 = grants_seen;
        for (int i = 0; i < 9; i++) send_one(4'(i), 128'(i + 200));
        repeat (5) tick();
        check("t4_grants", 64'(grants_seen - g0), 64'd8);
        check("t4_req_dropped", {63'd0, host_if.write_request}, 64'd0);
        check("t4_newest_fenced", {60'd0, newest}, 64'd0);
        oldest = 4'd9;
        ack_limit = 1000000;
        repeat (15) tick();
        check("t4_newest8", {60'd0, newest}, 64'd8);
        oldest = 4'd0;
        wait_idle();
        check("t4_newest9", {60'd0, newest}, 64'd9);

        // Same-cycle grant and ack with three writes outstanding
        do_reset();
        ack_limit = acks_sent;
        for (int i = 0; i < 3; i++) send_one(4'(i), 128'(i + 300));
        repeat (3) tick();
        grant_en = 1'b0;
        send_one(4'd3, 128'd303);
        tick();
        grant_en = 1'b1;
        ack_limit = acks_sent + 1;
        repeat (3) tick();
        ack_limit = acks_sent + 2;
        repeat (8) tick();
        check("t5_still_fenced", {60'd0, newest}, 64'd0);
        ack_limit = acks_sent + 1;
        repeat (8) tick();
        check("t5_newest4", {60'd0, newest}, 64'd4);
        ack_limit = 1000000;

        // Reset in the middle of filling a line
        do_reset();
        send_chunk(16'd6, d[0]);
        send_chunk(16'd6, d[1]);
        do_reset();
        check("t6_rdy", {63'd0, tx_rdy}, 64'd1);
        check("t6_no_req", {63'd0, host_if.write_request}, 64'd0);
        check("t6_newest", {60'd0, newest}, 64'd0);
        send_one(4'd0, 128'hBEEF);
        wait_idle();
        check("t6_newest1", {60'd0, newest}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
